up_down_clock_conditioner: RTL and testbench

Front-end for the synchronous up/down decade counter. Takes three raw, bouncing, active-low pushbuttons (up, down, load) and turns each press into one clean, single, active-low pulse on CPu, CPd or PL_n, timed to the system clock. Pulses are mutually exclusive, so the downstream counter never sees one count clock low while the other clock or parallel-load is active. Sits directly upstream of the counter; the counter's count edge is the rising edge that ends each CPu/CPd pulse.

---
 rtl/up_down_clock_conditioner_pkg.sv | 42 ++++
 rtl/up_down_clock_conditioner_button_debounce_sync.sv | 47 ++++
 rtl/up_down_clock_conditioner.sv | 128 ++++++++++++
 tb/tb_up_down_clock_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_clock_conditioner_pkg.sv
// Shared types and helpers for the up/down counter clock conditioner.
//   state_e      : FSM state encoding
//   sel_e        : source select code, doubles as the pending-flag bit index
//   strobes_t    : the three active-low strobes driven to the counter
package up_down_clock_conditioner_pkg;

  localparam int unsigned NUM_SRC = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_LD = 2'd0,
    SEL_UP = 2'd1,
    SEL_DN = 2'd2
  } sel_e;

  typedef struct packed {
    logic pl_n;
    logic cpu;
    logic cpd;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

  // Strobe pattern with only the selected source's line pulled low.
  function automatic strobes_t sel_strobes(sel_e sel);
    strobes_t s;
    s = STROBES_IDLE;
    case (sel)
      SEL_LD:  s.pl_n = 1'b0;
      SEL_UP:  s.cpu  = 1'b0;
      SEL_DN:  s.cpd  = 1'b0;
      default: s      = STROBES_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/up_down_clock_conditioner_button_debounce_sync.sv
// Synchronizes one raw active-low button, debounces it and emits a
// one-cycle press pulse on each accepted 1->0 transition.
//   clk, rst_n : clock, async active-low reset
//   btn_n      : raw button, asynchronous to clk
//   press      : registered one-cycle pulse per accepted press
module button_debounce_sync #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter runs while the synced level disagrees with the debounced one;
  // the DEB_CYCLES-th consecutive disagreement flips the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
        press <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/up_down_clock_conditioner.sv
// Turns three bouncing pushbuttons into clean, mutually exclusive,
// active-low count/load strobes for the up/down decade counter.
//   CP, MR_n      : clock, async active-low master reset
//   UP_n/DN_n/LD_n: raw active-low buttons
//   CPu/CPd/PL_n  : registered strobes, idle high, at most one low at a time
//   BUSY          : registered, high while a pulse/gap runs or an event waits
module up_down_clock_conditioner
  import up_down_clock_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned GAP_W      = 2
) (
  input  logic CP,
  input  logic MR_n,
  input  logic UP_n,
  input  logic DN_n,
  input  logic LD_n,
  output logic CPu,
  output logic CPd,
  output logic PL_n,
  output logic BUSY
);

  localparam int unsigned PH_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  logic [NUM_SRC-1:0] press;
  logic [NUM_SRC-1:0] pend_q, pend_d, pend_clr;
  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  strobes_t           strb_q, strb_d;
  logic               busy_q, busy_d;
  sel_e               sel_c;
  logic               start_c;

  button_debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_ld (
    .clk(CP), .rst_n(MR_n), .btn_n(LD_n), .press(press[SEL_LD])
  );
  button_debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(CP), .rst_n(MR_n), .btn_n(UP_n), .press(press[SEL_UP])
  );
  button_debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .clk(CP), .rst_n(MR_n), .btn_n(DN_n), .press(press[SEL_DN])
  );

  // Fixed priority LD > UP > DN among pending events.
  always_comb begin
    sel_c = SEL_DN;
    if (pend_q[SEL_LD])      sel_c = SEL_LD;
    else if (pend_q[SEL_UP]) sel_c = SEL_UP;
  end

  // Next-state logic. The last GAP cycle arbitrates directly so the all-high
  // interval between back-to-back pulses is exactly GAP_W cycles.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    strb_d   = strb_q;
    start_c  = 1'b0;
    pend_clr = '0;
    case (state_q)
      ST_IDLE: begin
        strb_d = STROBES_IDLE;
        if (|pend_q) start_c = 1'b1;
      end
      ST_PULSE: begin
        if (phase_q == PH_W'(PULSE_W - 1)) begin
          strb_d  = STROBES_IDLE;
          state_d = ST_GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_GAP: begin
        strb_d = STROBES_IDLE;
        if (phase_q == PH_W'(GAP_W - 1)) begin
          if (|pend_q) begin
            start_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        strb_d  = STROBES_IDLE;
      end
    endcase
    if (start_c) begin
      state_d         = ST_PULSE;
      phase_d         = '0;
      strb_d          = sel_strobes(sel_c);
      pend_clr[sel_c] = 1'b1;
    end
    // A press landing on the cycle its flag is consumed re-arms the flag.
    pend_d = (pend_q & ~pend_clr) | press;
    busy_d = (state_d != ST_IDLE) | (|pend_d);
  end

  // State, pending flags and output registers.
  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pend_q  <= '0;
      strb_q  <= STROBES_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
    end
  end

  assign CPu  = strb_q.cpu;
  assign CPd  = strb_q.cpd;
  assign PL_n = strb_q.pl_n;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_up_down_clock_conditioner.sv
// Self-checking bench for up_down_clock_conditioner: directed scenarios plus
// random button activity, every cycle compared against an event-level model.
module tb_up_down_clock_conditioner;

  localparam int D  = 4;
  localparam int PW = 2;
  localparam int GW = 2;

  logic CP   = 1'b0;
  logic MR_n = 1'b0;
  logic UP_n = 1'b1;
  logic DN_n = 1'b1;
  logic LD_n = 1'b1;
  logic CPu, CPd, PL_n, BUSY;

  up_down_clock_conditioner #(
    .DEB_CYCLES(D), .PULSE_W(PW), .GAP_W(GW)
  ) dut (
    .CP(CP), .MR_n(MR_n), .UP_n(UP_n), .DN_n(DN_n), .LD_n(LD_n),
    .CPu(CPu), .CPd(CPd), .PL_n(PL_n), .BUSY(BUSY)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Event-level model. Source index: 0=LD, 1=UP, 2=DN.
  // hist[i][j] is the raw sample taken j+1 edges before the current one.
  int m_k;
  int m_next_start;
  int m_start;
  int m_sel;
  bit m_pend  [3];
  bit m_press [3];
  bit m_deb   [3];
  bit hist    [3][0:D];
  int falls   [3];
  bit prev_lo [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i]  = 1'b0;
      m_press[i] = 1'b0;
      m_deb[i]   = 1'b1;
      for (int j = 0; j <= D; j++) hist[i][j] = 1'b1;
    end
    m_next_start = 0;
    m_start      = -1000;
    m_sel        = -1;
  endfunction

  function automatic bit exp_low(input int i);
    return (m_sel == i) && (m_k >= m_start) && (m_k < m_start + PW);
  endfunction

  function automatic void model_edge(input bit ld, input bit up, input bit dn, input bit mr);
    bit s [3];
    bit all_diff;
    bit found;
    s[0] = ld; s[1] = up; s[2] = dn;
    m_k++;
    if (!mr) begin
      model_reset();
      return;
    end
    // Issue the highest-priority waiting event once the previous pulse+gap is over.
    found = 1'b0;
    if (m_k >= m_next_start) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && m_pend[i]) begin
          found        = 1'b1;
          m_sel        = i;
          m_start      = m_k;
          m_next_start = m_k + PW + GW;
          m_pend[i]    = 1'b0;
        end
      end
    end
    // Presses accepted on the previous edge become visible flags now.
    for (int i = 0; i < 3; i++) begin
      if (m_press[i]) m_pend[i] = 1'b1;
      m_press[i] = 1'b0;
    end
    // Accept a level change when the D most recent synchronized samples
    // (raw samples 2..D+1 edges old) all disagree with the accepted level.
    for (int i = 0; i < 3; i++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[i][j] == m_deb[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_deb[i]   = ~m_deb[i];
        m_press[i] = (m_deb[i] == 1'b0);
      end
      for (int j = D; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = s[i];
    end
  endfunction

  function automatic bit exp_busy();
    return (m_k < m_next_start) || m_pend[0] || m_pend[1] || m_pend[2];
  endfunction

  // One clock: drive on the falling edge, model the rising edge, compare 1 ns later.
  task automatic step(input bit up, input bit dn, input bit ld, input bit mr);
    bit lo [3];
    @(negedge CP);
    UP_n = up; DN_n = dn; LD_n = ld; MR_n = mr;
    @(posedge CP);
    model_edge(ld, up, dn, mr);
    #1;
    check("PL_n", int'(PL_n), int'(!exp_low(0)));
    check("CPu",  int'(CPu),  int'(!exp_low(1)));
    check("CPd",  int'(CPd),  int'(!exp_low(2)));
    check("BUSY", int'(BUSY), int'(exp_busy()));
    lo[0] = !PL_n; lo[1] = !CPu; lo[2] = !CPd;
    for (int i = 0; i < 3; i++) begin
      if (lo[i] && !prev_lo[i]) falls[i]++;
      prev_lo[i] = lo[i];
    end
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) step(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  int lat, w, f0, reached;
  int hold [3];
  bit lvl  [3];

  initial begin
    m_k = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      falls[i] = 0; prev_lo[i] = 1'b0; hold[i] = 0; lvl[i] = 1'b1;
    end

    // Reset held, then quiet.
    for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("reset_no_pulses", falls[0] + falls[1] + falls[2], 0);

    // Single UP press: fixed latency, exact width, one pulse only.
    f0 = falls[1]; lat = -1; w = 0;
    for (int t = 1; t <= 30; t++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (lat < 0 && CPu == 1'b0) lat = t;
      if (CPu == 1'b0) w++;
    end
    idle(20);
    check("up_latency", lat, D + 4);
    check("up_width", w, PW);
    check("up_count", falls[1] - f0, 1);
    check("up_others", falls[0] + falls[2], 0);

    // Short DN glitch: no event.
    f0 = falls[2];
    for (int t = 0; t < D - 1; t++) step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(20);
    check("dn_glitch", falls[2] - f0, 0);

    // UP bouncing every cycle then settling low: one pulse.
    f0 = falls[1];
    for (int t = 0; t < 10; t++) step(bit'(t % 2), 1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 30; t++) step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    check("bounce_count", falls[1] - f0, 1);

    // All three at once: LD, then UP, then DN, each separated by the gap.
    for (int i = 0; i < 3; i++) falls[i] = 0;
    for (int t = 0; t < 40; t++) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("simul_ld", falls[0], 1);
    check("simul_up", falls[1], 1);
    check("simul_dn", falls[2], 1);

    // Reset during a CPu pulse with DN still pending.
    reached = 0;
    for (int t = 0; t < 40 && reached == 0; t++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      if (CPu == 1'b0) reached = 1;
    end
    check("midrst_reach", reached, 1);
    #2 MR_n = 1'b0;
    #1;
    check("midrst_CPu", int'(CPu), 1);
    check("midrst_CPd", int'(CPd), 1);
    check("midrst_BUSY", int'(BUSY), 0);
    for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 1'b1, 1'b0);
    f0 = falls[2];
    idle(30);
    check("midrst_no_dn", falls[2] - f0, 0);

    // LD held through reset release: one PL_n pulse at fixed latency.
    f0 = falls[0]; lat = -1;
    for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 30; t++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      if (lat < 0 && PL_n == 1'b0) lat = t;
    end
    idle(20);
    check("held_latency", lat, D + 4);
    check("held_count", falls[0] - f0, 1);

    // Random button activity with rare reset pulses.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = ($urandom_range(0, 2) != 0);
          hold[i] = $urandom_range(1, 2 * D + 6);
        end
        hold[i]--;
      end
      step(lvl[1], lvl[2], lvl[0], $urandom_range(0, 499) != 0);
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
